regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
- Register file and write-back stage for the 32-bit ALU datapath.
- Upstream of the ALU: two combinational read ports supply op1/op2.
- Downstream of the ALU: a write-back port captures the ALU result and its V/N/Z flags.
- Keeps a per-register pending scoreboard so issue logic can stall on read-after-write hazards.

Parameters:
- DATA_W, 32, data width of each register and of the write-back data.
- ADDR_W, 5, register address width.
- NREGS, 32, number of registers; r0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rs_addr  in  ADDR_W  read port A address.
- rt_addr  in  ADDR_W  read port B address.
- rs_data  out  DATA_W  read port A data, drives ALU op1.
- rt_data  out  DATA_W  read port B data, drives ALU op2.
- rs_pending  out  1  port A register has an outstanding write.
- rt_pending  out  1  port B register has an outstanding write.
- iss_valid  in  1  an instruction issues this cycle.
- iss_dest  in  ADDR_W  destination of the issuing instruction.
- wb_valid  in  1  write-back this cycle.
- wb_addr  in  ADDR_W  write-back destination.
- wb_data  in  DATA_W  ALU result.
- wb_flags_en  in  1  update status register on this write-back.
- v_in, n_in, z_in  in  1 each  ALU flags.
- clr_sticky  in  1  clear sticky overflow.
- status  out  4  {v_sticky, v, n, z}.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all pending bits 0, status 4'b0000. Read outputs then show 0.
- Reads are combinational, zero latency.
  - Address 0 always reads 0 and is never pending.
- Write: on a rising edge with wb_valid=1 and wb_addr!=0, reg[wb_addr] <= wb_data.
  - A write to address 0 is discarded; no register changes.
- Without bypass, read-after-write in the same cycle returns the old value. The new value is visible the cycle after the edge.
- Scoreboard, on each rising edge:
  - iss_valid=1 and iss_dest!=0: pending[iss_dest] <= 1.
  - wb_valid=1: pending[wb_addr] <= 0.
  - Same address set and cleared in the same cycle: set wins, because a newer producer is in flight.
  - rs_pending = pending[rs_addr]; rt_pending = pending[rt_addr].
- Status register, on a rising edge with wb_valid=1 and wb_flags_en=1:
  - {v, n, z} <= {v_in, n_in, z_in}.
  - This applies even when wb_addr=0, which allows compare-only operations.
- Sticky overflow, on each rising edge:
  - v_sticky <= 1 when the flags update with v_in=1.
  - Otherwise cleared by clr_sticky=1.
  - Overflow set and clr_sticky in the same cycle: set wins.
- Reset mid-operation: all pending bits are dropped. In-flight write-backs arriving after rst_n deasserts are still written normally.
- wb_valid=0: wb_addr, wb_data, wb_flags_en and flags are ignored.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: write-through bypass on both ports.
  - If wb_valid=1, wb_addr!=0 and wb_addr equals the read address, rs_data/rt_data return wb_data in the same cycle.
  - rs_pending/rt_pending are forced 0 for that match, unless iss_valid targets the same address in that cycle.
- Undefined: no bypass; the old value is returned as described above.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W, ADDR_W, ZERO_REG=0.
  - Status bit indices: Z=0, N=1, V=2, VS=3.
  - The 4-bit ALU control code constants (AND, OR, ADD, SUB, SLT, NOR, NAND, XOR, NOP) used by the ALU and its controller.
- One sub-module: regfile_wb_scoreboard, which holds the NREGS pending bit-vector, set/clear priority and the two pending lookups.

Test Plan:
- Reset, then read all 32 addresses -> every rs_data/rt_data = 0x0000_0000, rs_pending = 0, status = 4'b0000.
- wb_valid, wb_addr=5, wb_data=0xDEAD_BEEF; next cycle rs_addr=5, rt_addr=5 -> both read 0xDEADBEEF.
- Write 0x1234_5678 to r0, then read r0 -> 0x0000_0000.
- Same-cycle write/read of r7=0x0000_00AA:
  - bypass off -> old value, then 0xAA next cycle.
  - bypass on -> 0xAA in the same cycle.
- Scoreboard:
  - iss_valid, iss_dest=9 -> rs_pending=1 for rs_addr=9 from the next cycle.
  - wb_valid, wb_addr=9 -> clears next cycle.
  - Simultaneous iss_dest=9 and wb_addr=9 -> stays 1.
- Flags:
  - wb with wb_flags_en, v_in=1, n_in=1, z_in=0 -> status = 4'b1110.
  - Then flags 0,0,1 -> 4'b1001.
  - clr_sticky -> 4'b0001.
  - Assert rst_n=0 mid-sequence -> status immediately 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU datapath constants, status bit indices and ALU control codes
package alu_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    localparam int ST_Z  = 0;
    localparam int ST_N  = 1;
    localparam int ST_V  = 2;
    localparam int ST_VS = 3;

    typedef enum logic [3:0] {
        ALU_AND  = 4'h0,
        ALU_OR   = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_XOR  = 4'h3,
        ALU_SUB  = 4'h6,
        ALU_SLT  = 4'h7,
        ALU_NOR  = 4'hC,
        ALU_NAND = 4'hD,
        ALU_NOP  = 4'hF
    } alu_ctrl_e;
endpackage

// File: rtl/regfile_wb_if.sv
// rtl/regfile_wb_if.sv - read, issue, write-back and status signals of the register file
interface regfile_wb_if;
    import alu_pkg::*;

    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_pending;
    logic              rt_pending;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_dest;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_flags_en;
    logic              v_in;
    logic              n_in;
    logic              z_in;
    logic              clr_sticky;
    logic [3:0]        status;

    modport master (
        output rs_addr, rt_addr, iss_valid, iss_dest, wb_valid, wb_addr, wb_data,
               wb_flags_en, v_in, n_in, z_in, clr_sticky,
        input  rs_data, rt_data, rs_pending, rt_pending, status
    );

    modport slave (
        input  rs_addr, rt_addr, iss_valid, iss_dest, wb_valid, wb_addr, wb_data,
               wb_flags_en, v_in, n_in, z_in, clr_sticky,
        output rs_data, rt_data, rs_pending, rt_pending, status
    );
endinterface

// File: rtl/regfile_wb_scoreboard.sv
// rtl/regfile_wb_scoreboard.sv - per-register pending bits with set-over-clear priority
module regfile_wb_scoreboard
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid_i,
    input  logic [ADDR_W-1:0] iss_dest_i,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic              rs_pending_o,
    output logic              rt_pending_o
);
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Set applied after clear: a newly issued producer outranks the retiring one.
    always_comb begin
        pend_d = pend_q;
        if (wb_valid_i) pend_d[wb_addr_i] = 1'b0;
        if (iss_valid_i && iss_dest_i != ZERO_REG) pend_d[iss_dest_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign rs_pending_o = pend_q[rs_addr_i];
    assign rt_pending_o = pend_q[rt_addr_i];
endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - register file, write-back and status; REGFILE_WB_BYPASS_EN adds write-through bypass
module regfile_wb
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    regfile_wb_if.slave   bus
);
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [3:0]        status_q;
    logic [3:0]        status_d;
    logic              wr_en;
    logic              flag_upd;
    logic [DATA_W-1:0] rs_raw;
    logic [DATA_W-1:0] rt_raw;
    logic              rs_pend_raw;
    logic              rt_pend_raw;

    assign wr_en    = bus.wb_valid && (bus.wb_addr != ZERO_REG);
    assign flag_upd = bus.wb_valid && bus.wb_flags_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Flags also update on r0 write-backs so compare-only ops can set status.
    always_comb begin
        status_d = status_q;
        if (flag_upd) begin
            status_d[ST_V] = bus.v_in;
            status_d[ST_N] = bus.n_in;
            status_d[ST_Z] = bus.z_in;
        end
        if (flag_upd && bus.v_in) status_d[ST_VS] = 1'b1;
        else if (bus.clr_sticky)  status_d[ST_VS] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_q <= 4'b0000;
        else        status_q <= status_d;
    end

    assign bus.status = status_q;

    regfile_wb_scoreboard u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .iss_valid_i  (bus.iss_valid),
        .iss_dest_i   (bus.iss_dest),
        .wb_valid_i   (bus.wb_valid),
        .wb_addr_i    (bus.wb_addr),
        .rs_addr_i    (bus.rs_addr),
        .rt_addr_i    (bus.rt_addr),
        .rs_pending_o (rs_pend_raw),
        .rt_pending_o (rt_pend_raw)
    );

    assign rs_raw = (bus.rs_addr == ZERO_REG) ? '0 : regs_q[bus.rs_addr];
    assign rt_raw = (bus.rt_addr == ZERO_REG) ? '0 : regs_q[bus.rt_addr];

`ifdef REGFILE_WB_BYPASS_EN
    logic rs_hit, rt_hit, rs_iss, rt_iss;

    assign rs_hit = wr_en && (bus.wb_addr == bus.rs_addr);
    assign rt_hit = wr_en && (bus.wb_addr == bus.rt_addr);
    assign rs_iss = bus.iss_valid && (bus.iss_dest == bus.rs_addr);
    assign rt_iss = bus.iss_valid && (bus.iss_dest == bus.rt_addr);

    assign bus.rs_data    = rs_hit ? bus.wb_data : rs_raw;
    assign bus.rt_data    = rt_hit ? bus.wb_data : rt_raw;
    assign bus.rs_pending = rs_pend_raw && !(rs_hit && !rs_iss);
    assign bus.rt_pending = rt_pend_raw && !(rt_hit && !rt_iss);
`else
    assign bus.rs_data    = rs_raw;
    assign bus.rt_data    = rt_raw;
    assign bus.rs_pending = rs_pend_raw;
    assign bus.rt_pending = rt_pend_raw;
`endif
endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - self-checking bench for regfile_wb with a behavioural reference model
module tb_regfile_wb;
    import alu_pkg::*;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_wb_if bus ();
    regfile_wb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_v, m_n, m_z, m_vs;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP && bus.wb_valid && bus.wb_addr == a) return bus.wb_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_pend(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (BYP && bus.wb_valid && bus.wb_addr == a && !(bus.iss_valid && bus.iss_dest == a)) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
        {m_vs, m_v, m_n, m_z} = 4'b0000;
    endtask

    task automatic model_edge();
        bit upd;
        upd = bus.wb_valid && bus.wb_flags_en;
        if (bus.wb_valid && bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
        if (bus.wb_valid) m_pend[bus.wb_addr] = 1'b0;
        if (bus.iss_valid && bus.iss_dest != 0) m_pend[bus.iss_dest] = 1'b1;
        if (upd && bus.v_in) m_vs = 1'b1;
        else if (bus.clr_sticky) m_vs = 1'b0;
        if (upd) {m_v, m_n, m_z} = {bus.v_in, bus.n_in, bus.z_in};
    endtask

    task automatic idle();
        bus.rs_addr = '0; bus.rt_addr = '0;
        bus.iss_valid = 1'b0; bus.iss_dest = '0;
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.wb_flags_en = 1'b0; bus.v_in = 1'b0; bus.n_in = 1'b0; bus.z_in = 1'b0;
        bus.clr_sticky = 1'b0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.rs_addr = a[4:0];
            bus.rt_addr = 5'(31 - a);
            #1;
            n_checks += 4;
            if (bus.rs_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs a=%0d got %h exp 0", a, bus.rs_data); end
            if (bus.rt_data !== 32'h0) begin n_fail++; $display("FAIL reset_rt a=%0d got %h exp 0", a, bus.rt_data); end
            if (bus.rs_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pend a=%0d got %b exp 0", a, bus.rs_pending); end
            if (bus.status !== 4'b0000) begin n_fail++; $display("FAIL reset_status got %b exp 0000", bus.status); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        idle();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
        #1 tick();
        idle();
        bus.rs_addr = 5'd5; bus.rt_addr = 5'd5;
        #1;
        n_checks += 2;
        if (bus.rs_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rs got %h exp deadbeef", bus.rs_data); end
        if (bus.rt_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rt got %h exp deadbeef", bus.rt_data); end
    endtask

    task automatic test_r0();
        idle();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234_5678;
        #1 tick();
        idle();
        bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
        #1;
        n_checks += 2;
        if (bus.rs_data !== 32'h0) begin n_fail++; $display("FAIL r0_rs got %h exp 0", bus.rs_data); end
        if (bus.rt_data !== 32'h0) begin n_fail++; $display("FAIL r0_rt got %h exp 0", bus.rt_data); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_now;
        idle();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h0000_0011;
        #1 tick();
        idle();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h0000_00AA;
        bus.rs_addr = 5'd7; bus.rt_addr = 5'd7;
        #1;
        exp_now = BYP ? 32'h0000_00AA : 32'h0000_0011;
        n_checks += 2;
        if (bus.rs_data !== exp_now) begin n_fail++; $display("FAIL same_rs got %h exp %h", bus.rs_data, exp_now); end
        if (bus.rt_data !== exp_now) begin n_fail++; $display("FAIL same_rt got %h exp %h", bus.rt_data, exp_now); end
        tick();
        idle();
        bus.rs_addr = 5'd7;
        #1;
        n_checks++;
        if (bus.rs_data !== 32'h0000_00AA) begin n_fail++; $display("FAIL same_next got %h exp 000000aa", bus.rs_data); end
    endtask

    task automatic test_scoreboard();
        logic exp_p;
        idle();
        bus.iss_valid = 1'b1; bus.iss_dest = 5'd9; bus.rs_addr = 5'd9;
        #1;
        n_checks++;
        if (bus.rs_pending !== 1'b0) begin n_fail++; $display("FAIL sb_pre got %b exp 0", bus.rs_pending); end
        tick();
        idle();
        bus.rs_addr = 5'd9; bus.rt_addr = 5'd9;
        #1;
        n_checks += 2;
        if (bus.rs_pending !== 1'b1) begin n_fail++; $display("FAIL sb_set_rs got %b exp 1", bus.rs_pending); end
        if (bus.rt_pending !== 1'b1) begin n_fail++; $display("FAIL sb_set_rt got %b exp 1", bus.rt_pending); end
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h0000_0909;
        #1;
        exp_p = BYP ? 1'b0 : 1'b1;
        n_checks++;
        if (bus.rs_pending !== exp_p) begin n_fail++; $display("FAIL sb_wb_same got %b exp %b", bus.rs_pending, exp_p); end
        tick();
        idle();
        bus.rs_addr = 5'd9;
        #1;
        n_checks++;
        if (bus.rs_pending !== 1'b0) begin n_fail++; $display("FAIL sb_clear got %b exp 0", bus.rs_pending); end
        bus.iss_valid = 1'b1; bus.iss_dest = 5'd9;
        #1 tick();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd9;
        #1 tick();
        idle();
        bus.rs_addr = 5'd9;
        #1;
        n_checks++;
        if (bus.rs_pending !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins got %b exp 1", bus.rs_pending); end
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd9;
        #1 tick();
        idle();
        bus.iss_valid = 1'b1; bus.iss_dest = 5'd0;
        #1 tick();
        idle();
        #1;
        n_checks++;
        if (bus.rs_pending !== 1'b0) begin n_fail++; $display("FAIL sb_r0 got %b exp 0", bus.rs_pending); end
    endtask

    task automatic test_flags();
        idle();
        bus.wb_valid = 1'b1; bus.wb_flags_en = 1'b1; bus.wb_addr = 5'd0;
        {bus.v_in, bus.n_in, bus.z_in} = 3'b110;
        #1 tick();
        idle();
        #1;
        n_checks++;
        if (bus.status !== 4'b1110) begin n_fail++; $display("FAIL flags_1110 got %b exp 1110", bus.status); end
        bus.wb_valid = 1'b1; bus.wb_flags_en = 1'b1; {bus.v_in, bus.n_in, bus.z_in} = 3'b001;
        #1 tick();
        idle();
        #1;
        n_checks++;
        if (bus.status !== 4'b1001) begin n_fail++; $display("FAIL flags_1001 got %b exp 1001", bus.status); end
        bus.clr_sticky = 1'b1;
        #1 tick();
        idle();
        #1;
        n_checks++;
        if (bus.status !== 4'b0001) begin n_fail++; $display("FAIL flags_clr got %b exp 0001", bus.status); end
        bus.wb_valid = 1'b1; bus.wb_flags_en = 1'b1; {bus.v_in, bus.n_in, bus.z_in} = 3'b100;
        bus.clr_sticky = 1'b1;
        #1 tick();
        idle();
        #1;
        n_checks++;
        if (bus.status !== 4'b1100) begin n_fail++; $display("FAIL flags_set_wins got %b exp 1100", bus.status); end
        bus.wb_flags_en = 1'b1; {bus.v_in, bus.n_in, bus.z_in} = 3'b011;
        #1 tick();
        idle();
        #1;
        n_checks++;
        if (bus.status !== 4'b1100) begin n_fail++; $display("FAIL flags_no_valid got %b exp 1100", bus.status); end
    endtask

    task automatic test_reset_mid();
        idle();
        bus.iss_valid = 1'b1; bus.iss_dest = 5'd3;
        #1 tick();
        idle();
        bus.rs_addr = 5'd3; bus.rt_addr = 5'd5;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks += 3;
        if (bus.status !== 4'b0000) begin n_fail++; $display("FAIL rstmid_status got %b exp 0000", bus.status); end
        if (bus.rs_pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_pend got %b exp 0", bus.rs_pending); end
        if (bus.rt_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_data got %h exp 0", bus.rt_data); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h0000_0055;
        tick();
        idle();
        bus.rs_addr = 5'd4;
        #1;
        n_checks++;
        if (bus.rs_data !== 32'h0000_0055) begin n_fail++; $display("FAIL rstmid_inflight got %h exp 00000055", bus.rs_data); end
    endtask

    task automatic test_random();
        logic [31:0] e_rs, e_rt;
        bit          e_ps, e_pt;
        for (int c = 0; c < 400; c++) begin
            bus.rs_addr     = 5'($urandom_range(0, 15));
            bus.rt_addr     = 5'($urandom_range(0, 15));
            bus.iss_valid   = 1'($urandom_range(0, 1));
            bus.iss_dest    = 5'($urandom_range(0, 15));
            bus.wb_valid    = 1'($urandom_range(0, 1));
            bus.wb_addr     = 5'($urandom_range(0, 15));
            bus.wb_data     = $urandom;
            bus.wb_flags_en = 1'($urandom_range(0, 1));
            bus.v_in        = 1'($urandom_range(0, 1));
            bus.n_in        = 1'($urandom_range(0, 1));
            bus.z_in        = 1'($urandom_range(0, 1));
            bus.clr_sticky  = ($urandom_range(0, 3) == 0);
            #1;
            e_rs = exp_rd(bus.rs_addr);
            e_rt = exp_rd(bus.rt_addr);
            e_ps = exp_pend(bus.rs_addr);
            e_pt = exp_pend(bus.rt_addr);
            n_checks += 5;
            if (bus.rs_data !== e_rs) begin n_fail++; $display("FAIL rnd_rs c=%0d got %h exp %h", c, bus.rs_data, e_rs); end
            if (bus.rt_data !== e_rt) begin n_fail++; $display("FAIL rnd_rt c=%0d got %h exp %h", c, bus.rt_data, e_rt); end
            if (bus.rs_pending !== e_ps) begin n_fail++; $display("FAIL rnd_ps c=%0d got %b exp %b", c, bus.rs_pending, e_ps); end
            if (bus.rt_pending !== e_pt) begin n_fail++; $display("FAIL rnd_pt c=%0d got %b exp %b", c, bus.rt_pending, e_pt); end
            if (bus.status !== {m_vs, m_v, m_n, m_z}) begin
                n_fail++; $display("FAIL rnd_status c=%0d got %b exp %b", c, bus.status, {m_vs, m_v, m_n, m_z});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_r0();
        test_same_cycle();
        test_scoreboard();
        test_flags();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
